register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 92 +++++++++
 tb/tb_register_file.sv | 136 +++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32-entry register file: one write port, three registered read ports with
// write-first bypass, and a combinational view of the stack pointer (reg 31).

module rf_read_port #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [4:0]       addr,
  input  logic [WIDTH-1:0] stored,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data
);
  // A write landing on the same index this cycle wins over stale storage.
  always_ff @(posedge clk) begin
    if (reset)    data <= '0;
    else if (req) data <= (wr_en && wr_addr == addr) ? wr_data : stored;
  end
endmodule

module register_file #(
  parameter int WIDTH   = 64,
  parameter int NREGS   = 32,
  parameter int SP_INIT = 524288
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [4:0]              wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    rd_req,
  input  logic [4:0]              rd_addr,
  input  logic [4:0]              rs_addr,
  input  logic [4:0]              rt_addr,
  output logic signed [WIDTH-1:0] rd_data,
  output logic signed [WIDTH-1:0] rs_data,
  output logic signed [WIDTH-1:0] rt_data,
  output logic                    rd_valid,
  output logic signed [WIDTH-1:0] sp_out
);
  localparam int NPORTS = 3;
  localparam int SP_IDX = NREGS - 1;

  logic [WIDTH-1:0] regs [NREGS];

  logic [NPORTS-1:0][4:0]       raddr;
  logic [NPORTS-1:0][WIDTH-1:0] rstored;
  logic [NPORTS-1:0][WIDTH-1:0] rdata;

  assign raddr = {rt_addr, rs_addr, rd_addr};

  // No hard-wired zero: every index, including 0, is writable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_IDX) ? WIDTH'(SP_INIT) : '0;
    end else if (wr_en && 32'(wr_addr) < NREGS) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= rd_req;
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign rstored[p] = (32'(raddr[p]) < NREGS) ? regs[raddr[p]] : '0;

    rf_read_port #(.WIDTH(WIDTH)) u_port (
      .clk     (clk),
      .reset   (reset),
      .req     (rd_req),
      .addr    (raddr[p]),
      .stored  (rstored[p]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rdata[p])
    );
  end

  assign rd_data = rdata[0];
  assign rs_data = rdata[1];
  assign rt_data = rdata[2];

  // Straight from storage; a write to the stack pointer shows up after the edge.
  assign sp_out = regs[SP_IDX];
endmodule

// File: tb/tb_register_file.sv
// Directed scenarios plus randomized traffic against an array-based model.
module tb_register_file;
  localparam int          WIDTH   = 64;
  localparam logic [63:0] SP_INIT = 64'd524288;

  logic                    clk = 1'b0;
  logic                    reset, wr_en, rd_req;
  logic [4:0]              wr_addr, rd_addr, rs_addr, rt_addr;
  logic signed [WIDTH-1:0] wr_data;
  logic signed [WIDTH-1:0] rd_data, rs_data, rt_data, sp_out;
  logic                    rd_valid;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [32];
  logic [63:0] m_rd, m_rs, m_rt;
  logic        m_valid;

  always #5 clk = ~clk;

  register_file #(.WIDTH(WIDTH), .NREGS(32), .SP_INIT(524288)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_data(rd_data), .rs_data(rs_data), .rt_data(rt_data),
    .rd_valid(rd_valid), .sp_out(sp_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [4:0] a, input bit we,
                                         input logic [4:0] wa, input logic [63:0] wd);
    return (we && wa == a) ? wd : m_regs[a];
  endfunction

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit rst, input bit we, input logic [4:0] wa, input logic [63:0] wd,
                      input bit rq, input logic [4:0] a_rd, input logic [4:0] a_rs,
                      input logic [4:0] a_rt);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_req = rq; rd_addr = a_rd; rs_addr = a_rs; rt_addr = a_rt;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = (i == 31) ? SP_INIT : 64'd0;
      m_rd = 0; m_rs = 0; m_rt = 0; m_valid = 0;
    end else begin
      m_valid = rq;
      if (rq) begin
        m_rd = m_read(a_rd, we, wa, wd);
        m_rs = m_read(a_rs, we, wa, wd);
        m_rt = m_read(a_rt, we, wa, wd);
      end
      if (we) m_regs[wa] = wd;
    end
    @(posedge clk);
    #1;
    chk("valid", {63'd0, rd_valid}, {63'd0, m_valid});
    chk("rd", rd_data, m_rd);
    chk("rs", rs_data, m_rs);
    chk("rt", rt_data, m_rt);
    chk("sp", sp_out, m_regs[31]);
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    step(0, 1, a, d, 0, 0, 0, 0);
  endtask

  task automatic rd3(input logic [4:0] a_rd, input logic [4:0] a_rs, input logic [4:0] a_rt);
    step(0, 0, 0, 0, 1, a_rd, a_rs, a_rt);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("sp_after_reset", sp_out, 64'd524288);
    chk("valid_after_reset", {63'd0, rd_valid}, 64'd0);

    rd3(31, 0, 5);
    chk("rst_rs0", rs_data, 64'd0);
    chk("rst_rt5", rt_data, 64'd0);
    chk("rst_rd31", rd_data, 64'd524288);
    chk("rst_valid", {63'd0, rd_valid}, 64'd1);

    wr(3, 64'h7FFF_FFFF_FFFF_FFFF);
    wr(4, -64'sd1);
    rd3(0, 3, 4);
    chk("max_pos", rs_data, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("minus1", rt_data, 64'hFFFF_FFFF_FFFF_FFFF);

    step(0, 1, 7, -64'sd42, 1, 7, 7, 7);
    chk("byp_rd", rd_data, 64'hFFFF_FFFF_FFFF_FFD6);
    chk("byp_rs", rs_data, 64'hFFFF_FFFF_FFFF_FFD6);
    chk("byp_rt", rt_data, 64'hFFFF_FFFF_FFFF_FFD6);

    step(1, 1, 31, 64'd5, 1, 31, 31, 31);
    chk("rst_prio_valid", {63'd0, rd_valid}, 64'd0);
    rd3(31, 0, 0);
    chk("rst_prio_sp", rd_data, 64'd524288);

    for (int i = 1; i <= 4; i++) wr(5'(i), 64'(i * 10));
    for (int i = 1; i <= 4; i++) begin
      rd3(0, 5'(i), 0);
      chk("stream_rs", rs_data, 64'(i * 10));
      chk("stream_valid", {63'd0, rd_valid}, 64'd1);
    end
    step(0, 0, 0, 0, 0, 9, 9, 9);
    chk("hold_valid", {63'd0, rd_valid}, 64'd0);
    chk("hold_rs", rs_data, 64'd40);

    wr(31, 64'd1000);
    chk("sp_write", sp_out, 64'd1000);
    wr(0, 64'd9);
    rd3(0, 0, 0);
    chk("reg0_write", rs_data, 64'd9);

    for (int n = 0; n < 400; n++) begin
      bit          r_rst, r_we, r_rq;
      logic [4:0]  a0, a1, a2, wa;
      logic [63:0] wd;
      r_rst = ($urandom_range(0, 29) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_rq  = $urandom_range(0, 3) != 0;
      a0 = 5'($urandom); a1 = 5'($urandom); a2 = 5'($urandom);
      wa = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
      wd = {$urandom, $urandom};
      step(r_rst, r_we, wa, wd, r_rq, a0, a1, a2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
